// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides the system clock down to a pixel rate
// and produces x/y coordinates, active-video, sync pulses and frame strobes.
module vga_timing_gen #(
    parameter int   CLKS_PER_PIXEL = 4,
    parameter int   XBITS          = 10,
    parameter int   YBITS          = 10,
    parameter int   H_VISIBLE      = 640,
    parameter int   H_FRONT        = 16,
    parameter int   H_SYNC         = 96,
    parameter int   H_BACK         = 48,
    parameter int   V_VISIBLE      = 480,
    parameter int   V_FRONT        = 10,
    parameter int   V_SYNC         = 2,
    parameter int   V_BACK         = 33,
    parameter logic SYNC_ACTIVE    = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [XBITS-1:0] x,
    output logic [YBITS-1:0] y,
    output logic             activevideo,
    output logic             hsync,
    output logic             vsync,
    output logic             pixel_tick,
    output logic             frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_FIRST = H_VISIBLE + H_FRONT;
    localparam int VS_FIRST = V_VISIBLE + V_FRONT;

    localparam logic [XBITS-1:0] X_LAST     = XBITS'(H_TOTAL - 1);
    localparam logic [XBITS-1:0] X_VIS      = XBITS'(H_VISIBLE);
    localparam logic [XBITS-1:0] X_HS_FIRST = XBITS'(HS_FIRST);
    localparam logic [XBITS-1:0] X_HS_LAST  = XBITS'(HS_FIRST + H_SYNC - 1);
    localparam logic [YBITS-1:0] Y_LAST     = YBITS'(V_TOTAL - 1);
    localparam logic [YBITS-1:0] Y_VIS      = YBITS'(V_VISIBLE);
    localparam logic [YBITS-1:0] Y_VS_FIRST = YBITS'(VS_FIRST);
    localparam logic [YBITS-1:0] Y_VS_LAST  = YBITS'(VS_FIRST + V_SYNC - 1);

    logic [XBITS-1:0] x_q;
    logic [YBITS-1:0] y_q;
    logic             tick;
    logic             line_wrap;
    logic             frame_wrap;
    logic             frame_start_q;

    // Gating the tick with resetn keeps pixel_tick low for the whole reset window.
    generate
        if (CLKS_PER_PIXEL > 1) begin : g_sub
            localparam int SUBW = $clog2(CLKS_PER_PIXEL);
            localparam logic [SUBW-1:0] SUB_LAST = SUBW'(CLKS_PER_PIXEL - 1);
            logic [SUBW-1:0] sub;

            always_ff @(posedge clk) begin
                if (!resetn) begin
                    sub <= '0;
                end else if (sub == SUB_LAST) begin
                    sub <= '0;
                end else begin
                    sub <= sub + SUBW'(1);
                end
            end

            assign tick = resetn && (sub == SUB_LAST);
        end else begin : g_nosub
            assign tick = resetn;
        end
    endgenerate

    assign line_wrap  = tick && (x_q == X_LAST);
    assign frame_wrap = line_wrap && (y_q == Y_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_wrap;
            if (line_wrap) begin
                x_q <= '0;
                if (y_q == Y_LAST) begin
                    y_q <= '0;
                end else begin
                    y_q <= y_q + YBITS'(1);
                end
            end else if (tick) begin
                x_q <= x_q + XBITS'(1);
            end
        end
    end

    // Decode is purely combinational so it lines up with the counters exactly.
    assign x           = x_q;
    assign y           = y_q;
    assign activevideo = (x_q < X_VIS) && (y_q < Y_VIS);
    assign hsync       = ((x_q >= X_HS_FIRST) && (x_q <= X_HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vsync       = ((y_q >= Y_VS_FIRST) && (y_q <= Y_VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign pixel_tick  = tick;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance for line timing, two
// scaled-down instances so frame wraps and the 1-clock-per-pixel mode fit in a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Scaled-down raster: 16 pixels x 13 lines.
    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
    localparam int SVV = 6, SVF = 2, SVS = 2, SVB = 3;

    logic rn_a = 1'b0, rn_b = 1'b0, rn_c = 1'b0;

    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic av_a, hs_a, vs_a, pt_a, fs_a;
    logic av_b, hs_b, vs_b, pt_b, fs_b;
    logic av_c, hs_c, vs_c, pt_c, fs_c;

    vga_timing_gen u_a (
        .clk(clk), .resetn(rn_a), .x(x_a), .y(y_a), .activevideo(av_a),
        .hsync(hs_a), .vsync(vs_a), .pixel_tick(pt_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .CLKS_PER_PIXEL(4),
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) u_b (
        .clk(clk), .resetn(rn_b), .x(x_b), .y(y_b), .activevideo(av_b),
        .hsync(hs_b), .vsync(vs_b), .pixel_tick(pt_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .CLKS_PER_PIXEL(1), .SYNC_ACTIVE(1'b1),
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) u_c (
        .clk(clk), .resetn(rn_c), .x(x_c), .y(y_c), .activevideo(av_c),
        .hsync(hs_c), .vsync(vs_c), .pixel_tick(pt_c), .frame_start(fs_c)
    );

    // Vector layout: {x[24:15], y[14:5], activevideo[4], hsync[3], vsync[2], pixel_tick[1], frame_start[0]}
    logic [24:0] exp_q[$];
    int n_cnt[3];
    int vectors = 0;
    int miscompares = 0;

    // Reference: everything derived from the clock count since the last reset edge.
    function automatic logic [24:0] model(input int d, input int n, input bit rn);
        int cpp, hv, hf, hsw, hb, vv, vf, vsw, vb, ht, vt, p, xx, yy;
        bit sa;
        logic av, hs, vs, pt, fs;
        if (d == 0) begin
            cpp = 4; hv = 640; hf = 16; hsw = 96; hb = 48;
            vv = 480; vf = 10; vsw = 2; vb = 33; sa = 1'b0;
        end else begin
            cpp = (d == 1) ? 4 : 1;
            hv = SHV; hf = SHF; hsw = SHS; hb = SHB;
            vv = SVV; vf = SVF; vsw = SVS; vb = SVB;
            sa = (d == 2);
        end
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        p  = n / cpp;
        xx = p % ht;
        yy = (p / ht) % vt;
        av = (xx < hv) && (yy < vv);
        hs = (xx >= hv + hf && xx < hv + hf + hsw) ? sa : !sa;
        vs = (yy >= vv + vf && yy < vv + vf + vsw) ? sa : !sa;
        pt = rn && ((n % cpp) == cpp - 1);
        fs = (n > 0) && ((n % (cpp * ht * vt)) == 0);
        return {10'(xx), 10'(yy), av, hs, vs, pt, fs};
    endfunction

    function automatic logic [24:0] obs(input int d);
        case (d)
            0:       return {x_a, y_a, av_a, hs_a, vs_a, pt_a, fs_a};
            1:       return {x_b, y_b, av_b, hs_b, vs_b, pt_b, fs_b};
            default: return {x_c, y_c, av_c, hs_c, vs_c, pt_c, fs_c};
        endcase
    endfunction

    // Drives resetn for one edge, queues the expected post-edge state, lands on the negedge.
    task automatic drive_cycle(input int d, input bit rn);
        case (d)
            0:       rn_a = rn;
            1:       rn_b = rn;
            default: rn_c = rn;
        endcase
        @(posedge clk);
        if (!rn) n_cnt[d] = 0;
        else     n_cnt[d] = n_cnt[d] + 1;
        exp_q.push_back(model(d, n_cnt[d], rn));
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [24:0] got, exp;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 1'b0);
            got = obs(0);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_model: got %h expected %h", got, exp);
            end
        end
        vectors++;
        if (got !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_defaults: got %h expected %h", got, {10'd0, 10'd0, 5'b11100});
        end
    endtask

    task automatic test_horizontal;
        logic [24:0] got, exp;
        int hs_low = 0;
        for (int i = 0; i < 6410; i++) begin
            drive_cycle(0, 1'b1);
            got = obs(0);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL horiz_model n=%0d: got %h expected %h", n_cnt[0], got, exp);
            end
            if (n_cnt[0] <= 3200 && got[3] == 1'b0) hs_low++;
            if (n_cnt[0] == 2559 || n_cnt[0] == 2560) begin
                vectors++;
                if (got[4] !== (n_cnt[0] == 2559)) begin
                    miscompares++;
                    $display("FAIL activevideo_edge n=%0d: got %b expected %b", n_cnt[0], got[4], n_cnt[0] == 2559);
                end
            end
            if (n_cnt[0] == 2623 || n_cnt[0] == 2624) begin
                vectors++;
                if (got[3] !== (n_cnt[0] == 2623)) begin
                    miscompares++;
                    $display("FAIL hsync_edge n=%0d: got %b expected %b", n_cnt[0], got[3], n_cnt[0] == 2623);
                end
            end
            if (n_cnt[0] == 3200) begin
                vectors++;
                if (got[24:5] !== {10'd0, 10'd1}) begin
                    miscompares++;
                    $display("FAIL line_wrap: got x=%0d y=%0d expected x=0 y=1", got[24:15], got[14:5]);
                end
            end
        end
        vectors++;
        if (hs_low != 384) begin
            miscompares++;
            $display("FAIL hsync_width: got %0d clocks expected 384", hs_low);
        end
    endtask

    task automatic test_frame_wrap;
        logic [24:0] got, exp;
        int fs_cnt = 0, pt_cnt = 0;
        for (int i = 0; i < 3330; i++) begin
            drive_cycle(1, i >= 2);
            got = obs(1);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL frame_model n=%0d: got %h expected %h", n_cnt[1], got, exp);
            end
            if (i >= 2) begin
                if (got[1]) pt_cnt++;
                if (got[0]) begin
                    fs_cnt++;
                    vectors++;
                    if (n_cnt[1] % 832 != 0 || got[24:5] !== 20'd0) begin
                        miscompares++;
                        $display("FAIL frame_start_pos: got pulse at n=%0d xy=%h expected n multiple of 832 at 0,0", n_cnt[1], got[24:5]);
                    end
                end
                if (got[14:5] >= 10'd6 && got[4]) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL vblank_active: got activevideo=1 at y=%0d expected 0", got[14:5]);
                end
            end
        end
        vectors++;
        if (fs_cnt != 4 || pt_cnt != 832) begin
            miscompares++;
            $display("FAIL frame_counts: got fs=%0d pt=%0d expected fs=4 pt=832", fs_cnt, pt_cnt);
        end
    endtask

    task automatic test_mid_frame_reset;
        logic [24:0] got, exp;
        bit found = 1'b0;
        for (int i = 0; i < 900 && !found; i++) begin
            drive_cycle(1, 1'b1);
            got = obs(1);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL midreset_pre n=%0d: got %h expected %h", n_cnt[1], got, exp);
            end
            if (((n_cnt[1] / 4) % 208) == 155) found = 1'b1;
        end
        vectors++;
        if (!found || got[3:2] !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_syncs: got found=%0d hs/vs=%b expected found=1 hs/vs=00", found, got[3:2]);
        end
        drive_cycle(1, 1'b0);
        got = obs(1);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0} || got !== exp) begin
            miscompares++;
            $display("FAIL midreset_state: got %h expected %h", got, exp);
        end
        for (int i = 0; i < 1000; i++) begin
            drive_cycle(1, 1'b1);
            got = obs(1);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL midreset_post n=%0d: got %h expected %h", n_cnt[1], got, exp);
            end
        end
    endtask

    task automatic test_cpp1;
        logic [24:0] got, exp;
        int last_fs = -1, fs_cnt = 0;
        for (int i = 0; i < 420; i++) begin
            drive_cycle(2, i >= 2);
            got = obs(2);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL cpp1_model n=%0d: got %h expected %h", n_cnt[2], got, exp);
            end
            if (i >= 2 && n_cnt[2] < 16) begin
                vectors++;
                if (got[24:15] !== 10'(n_cnt[2]) || got[3] !== (n_cnt[2] >= 10 && n_cnt[2] <= 12)) begin
                    miscompares++;
                    $display("FAIL cpp1_line n=%0d: got x=%0d hs=%b", n_cnt[2], got[24:15], got[3]);
                end
            end
            if (i >= 2 && (n_cnt[2] == 127 || n_cnt[2] == 128 || n_cnt[2] == 160)) begin
                vectors++;
                if (got[2] !== (n_cnt[2] == 128)) begin
                    miscompares++;
                    $display("FAIL cpp1_vsync n=%0d: got %b expected %b", n_cnt[2], got[2], n_cnt[2] == 128);
                end
            end
            if (i >= 2 && got[0]) begin
                fs_cnt++;
                if (last_fs >= 0) begin
                    vectors++;
                    if (n_cnt[2] - last_fs != 208) begin
                        miscompares++;
                        $display("FAIL cpp1_frame_period: got %0d expected 208", n_cnt[2] - last_fs);
                    end
                end
                last_fs = n_cnt[2];
            end
        end
        vectors++;
        if (fs_cnt != 2) begin
            miscompares++;
            $display("FAIL cpp1_frame_count: got %0d expected 2", fs_cnt);
        end
    endtask

    initial begin
        n_cnt = '{0, 0, 0};
        test_reset();
        test_horizontal();
        test_frame_wrap();
        test_mid_frame_reset();
        test_cpp1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing from the system clock.
- Produces pixel coordinates, active-video flag, and hsync/vsync directly consumable by the VGA display driver (x, y, activevideo, hsync, vsync).
- Divides the system clock into a pixel rate internally and adds pixel-tick and frame-start strobes for downstream pixel/frame-buffer logic.

Parameters:
- CLKS_PER_PIXEL, 4, system clocks per pixel (1 = every clock is a pixel); legal range 1..16
- XBITS, 10, width of x counter
- YBITS, 10, width of y counter
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of hsync/vsync during the pulse

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- x  out  XBITS  current column, 0..H_TOTAL-1
- y  out  YBITS  current line, 0..V_TOTAL-1
- activevideo  out  1  high when x<H_VISIBLE and y<V_VISIBLE
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- pixel_tick  out  1  high on the last clock of each pixel period
- frame_start  out  1  one-clock pulse on the first clock of pixel (0,0) of each new frame

Behaviour:
- Interface: one clock `clk`. Reset `resetn` is synchronous and active-low.
- Derived constants: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
- Sub-pixel counter `sub`:
  - Counts 0..CLKS_PER_PIXEL-1 and wraps to 0.
  - pixel_tick = (sub == CLKS_PER_PIXEL-1), combinational.
  - With CLKS_PER_PIXEL=1 there is no sub counter and pixel_tick is constantly 1 (0 only while resetn is low).
- x counter:
  - Increments on each clock where pixel_tick=1.
  - When x == H_TOTAL-1 and pixel_tick=1, x goes to 0 and y advances.
- y counter:
  - Increments when the line wraps.
  - When y == V_TOTAL-1 and the line wraps, y goes to 0.
- Decode (combinational from registered x, y; zero latency relative to the counters):
  - activevideo = (x < H_VISIBLE) && (y < V_VISIBLE).
  - hsync = SYNC_ACTIVE for x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751]; otherwise ~SYNC_ACTIVE.
  - vsync = SYNC_ACTIVE for y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491]; otherwise ~SYNC_ACTIVE. vsync depends on y only, so it spans whole lines including the horizontal blanking.
- frame_start:
  - Registered.
  - Set to 1 on the clock edge where the counters wrap from (x=H_TOTAL-1, y=V_TOTAL-1, last sub) to (0,0,0); cleared on every other edge.
  - Not asserted for the first frame after reset.
- Reset (resetn=0 sampled at a clk edge):
  - sub=0, x=0, y=0, frame_start=0.
  - Resulting outputs: x=0, y=0, activevideo=1, hsync=vsync=~SYNC_ACTIVE (1 at default), pixel_tick=0 during reset.
  - Counting resumes on the first edge with resetn=1.
- Reset mid-frame: counters return to 0 on that edge from any state. No sync glitch is required beyond the immediate deassertion of any active sync pulse.
- Counters never take values ≥ their TOTAL. No out-of-range states exist after reset.
- Widths: XBITS and YBITS must hold H_TOTAL-1 and V_TOTAL-1 respectively. Comparisons are unsigned.

Test Plan:
1. Reset hold, defaults: resetn=0 for 5 clocks -> x=0, y=0, activevideo=1, hsync=1, vsync=1, frame_start=0, pixel_tick=0.
2. Horizontal timing, CLKS_PER_PIXEL=4:
   - Release reset, count clocks.
   - x=639→640 (activevideo falls) after 2560 clocks.
   - hsync falls at clock 2624 and stays low 384 clocks.
   - x wraps to 0 and y=1 at clock 3200.
3. Vertical timing:
   - vsync falls when y becomes 490 (clock 490*3200=1,568,000), low for 6400 clocks.
   - activevideo stays 0 for all of y=480..524.
4. Frame wrap:
   - At clock 1,680,000 the counters return to (0,0).
   - frame_start is high for exactly that one clock.
   - It repeats every 1,680,000 clocks.
   - pixel_tick is high for exactly 1 of every 4 clocks throughout.
5. Mid-frame reset:
   - resetn=0 for 1 clock while x=700, y=491 (hsync and vsync both low).
   - Next edge: x=0, y=0, hsync=1, vsync=1, frame_start=0.
   - Timing in scenario 2 then repeats exactly.
6. CLKS_PER_PIXEL=1, SYNC_ACTIVE=1:
   - x advances every clock.
   - hsync is high for clocks 656..751 of each 800-clock line.
   - vsync is high for lines 490..491.
   - frame_start period is 420,000 clocks.
